cgm_switch_ctrl: RTL and testbench



---
 rtl/cgm_pkg.sv | 26 ++
 rtl/cgm_switch_ctrl_if.sv | 21 ++
 rtl/cgm_sync2.sv | 28 ++
 rtl/cgm_switch_ctrl.sv | 141 ++++++++++++++
 tb/tb_cgm_switch_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cgm_pkg.sv
// Shared types and helpers for the clock-mux switch controller.
// Sources, error codes and the request-select decode.
package cgm_pkg;

  typedef enum logic {
    IDLE,
    SWITCH
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TGT_BAD  = 2'b01;
  localparam logic [1:0] ERR_SRC_LOST = 2'b10;
  localparam logic [1:0] ERR_TGT_LOST = 2'b11;

  localparam logic [1:0] SRC0 = 2'd0;
  localparam logic [1:0] SRC1 = 2'd1;
  localparam logic [1:0] SRC2 = 2'd2;

  // Both 10 and 11 select src2 on the mux.
  function automatic logic [1:0] decode_sel(
    input logic [1:0] sel
  );
    return (sel == 2'b11) ? SRC2 : sel;
  endfunction

endpackage

// File: rtl/cgm_switch_ctrl_if.sv
// Software switch-request handshake.
// master drives the request, slave returns ready.
interface cgm_switch_ctrl_if;

  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_sel,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    output req_ready
  );

endinterface

// File: rtl/cgm_sync2.sv
// Two-flop synchronizer with a per-bit reset value.
// Used to bring clock-good status into the control domain.
module cgm_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_clk,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      s1 <= rst_val;
      s2 <= rst_val;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/cgm_switch_ctrl.sv
// Sequencer driving the 3-input glitch-free clock mux select.
// Handles software switches, settle hold-off and fallback to src0.
module cgm_switch_ctrl
  import cgm_pkg::*;
#(
  parameter int         SETTLE_CYC = 16,
  parameter int         CNT_W      = 4,
  parameter logic [1:0] RST_SEL    = 2'b00
) (
  input  logic               clk,
  input  logic               rst_clk,
  cgm_switch_ctrl_if.slave   req,
  input  logic [2:0]         src_ok,
  input  logic               fallback_en,
  output logic [1:0]         cgm_sel,
  output logic [1:0]         cur_src,
  output logic               busy,
  output logic               done_pulse,
  output logic               err_pulse,
  output logic [1:0]         err_code
);

  localparam logic [CNT_W-1:0] CNT_LD =
    CNT_W'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tgt_q, tgt_d;
  logic             is_fb_q, is_fb_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       cur_q, cur_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic [2:0] ok;
  logic [1:0] target;
  logic       fb_cond;
  logic       acc;

  cgm_sync2 #(.W(3)) u_sync (
    .clk     (clk),
    .rst_clk (rst_clk),
    .rst_val (3'b111),
    .d       (src_ok),
    .q       (ok)
  );

  assign target  = decode_sel(req.req_sel);
  assign fb_cond = fallback_en && (cur_q != SRC0)
                   && !ok[cur_q];
  assign req.req_ready = (state_q == IDLE) && !fb_cond;
  assign acc = req.req_valid && req.req_ready;

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= SRC0;
      is_fb_q <= 1'b0;
      sel_q   <= RST_SEL;
      cur_q   <= decode_sel(RST_SEL);
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      is_fb_q <= is_fb_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    is_fb_d = is_fb_q;
    sel_d   = sel_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        // Losing the active clock outranks any request.
        if (fb_cond) begin
          sel_d   = SRC0;
          tgt_d   = SRC0;
          is_fb_d = 1'b1;
          err_d   = 1'b1;
          code_d  = ERR_SRC_LOST;
          cnt_d   = CNT_LD;
          state_d = SWITCH;
        end else if (acc) begin
          if (target == cur_q) begin
            done_d = 1'b1;
          end else if (!ok[target]) begin
            err_d  = 1'b1;
            code_d = ERR_TGT_BAD;
          end else begin
            sel_d   = req.req_sel;
            tgt_d   = target;
            is_fb_d = 1'b0;
            cnt_d   = CNT_LD;
            state_d = SWITCH;
          end
        end
      end
      SWITCH: begin
        cnt_d = cnt_q - 1'b1;
        if (tgt_q != SRC0 && !ok[tgt_q]) begin
          sel_d   = SRC0;
          tgt_d   = SRC0;
          is_fb_d = 1'b1;
          err_d   = 1'b1;
          code_d  = ERR_TGT_LOST;
          cnt_d   = CNT_LD;
        end else if (cnt_q == '0) begin
          cur_d   = tgt_q;
          state_d = IDLE;
          done_d  = !is_fb_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cgm_sel    = sel_q;
  assign cur_src    = cur_q;
  assign busy       = (state_q == SWITCH);
  assign done_pulse = done_q;
  assign err_pulse  = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_cgm_switch_ctrl.sv
// Directed bench for cgm_switch_ctrl.
// Expected values are worked out by hand from the cycle timing.
module tb_cgm_switch_ctrl;

  logic       clk;
  logic       rst_clk;
  logic [2:0] src_ok;
  logic       fallback_en;
  logic [1:0] cgm_sel;
  logic [1:0] cur_src;
  logic       busy;
  logic       done_pulse;
  logic       err_pulse;
  logic [1:0] err_code;

  int n_chk;
  int n_pass;

  cgm_switch_ctrl_if rif ();

  cgm_switch_ctrl #(
    .SETTLE_CYC (16),
    .CNT_W      (4),
    .RST_SEL    (2'b00)
  ) dut (
    .clk         (clk),
    .rst_clk     (rst_clk),
    .req         (rif.slave),
    .src_ok      (src_ok),
    .fallback_en (fallback_en),
    .cgm_sel     (cgm_sel),
    .cur_src     (cur_src),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .err_pulse   (err_pulse),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a request for one cycle; returns one cycle after accept.
  task automatic do_req(input logic [1:0] s);
    rif.req_valid = 1'b1;
    rif.req_sel   = s;
    chk("req_ready", rif.req_ready, 1);
    tick();
    rif.req_valid = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
  endtask

  int nb;
  int k;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_clk = 1'b1;
    src_ok = 3'b111;
    fallback_en = 1'b0;
    rif.req_valid = 1'b0;
    rif.req_sel = 2'b00;
    ticks(3);
    chk("rst_sel", cgm_sel, 0);
    chk("rst_cur", cur_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_code", err_code, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_err", err_pulse, 0);
    rst_clk = 1'b0;
    ticks(2);

    // src0 -> src1: full settle latency
    do_req(2'b01);
    chk("sw1_sel", cgm_sel, 2'b01);
    chk("sw1_busy", busy, 1);
    chk("sw1_rdy", rif.req_ready, 0);
    chk("sw1_cur_mid", cur_src, 0);
    wait_busy(nb);
    chk("sw1_ncyc", nb, 16);
    chk("sw1_cur", cur_src, 1);
    chk("sw1_done", done_pulse, 1);
    chk("sw1_rdy2", rif.req_ready, 1);
    tick();
    chk("sw1_done_off", done_pulse, 0);

    // src1 -> src2 via select 11
    do_req(2'b11);
    chk("sw2_sel", cgm_sel, 2'b11);
    wait_busy(nb);
    chk("sw2_ncyc", nb, 16);
    chk("sw2_cur", cur_src, 2);
    chk("sw2_done", done_pulse, 1);
    tick();

    // same-target request: immediate done
    do_req(2'b10);
    chk("same_done", done_pulse, 1);
    chk("same_sel", cgm_sel, 2'b11);
    chk("same_busy", busy, 0);

    // back to src0, then reject a bad target
    tick();
    do_req(2'b00);
    wait_busy(nb);
    chk("sw0_cur", cur_src, 0);
    src_ok = 3'b101;
    ticks(3);
    do_req(2'b01);
    chk("bad_err", err_pulse, 1);
    chk("bad_code", err_code, 2'b01);
    chk("bad_sel", cgm_sel, 0);
    chk("bad_busy", busy, 0);
    chk("bad_done", done_pulse, 0);
    tick();
    chk("bad_err_off", err_pulse, 0);
    chk("bad_code_hold", err_code, 2'b01);
    src_ok = 3'b111;
    ticks(3);

    // fallback when the active source drops
    do_req(2'b10);
    wait_busy(nb);
    chk("fb_pre_cur", cur_src, 2);
    tick();
    fallback_en = 1'b1;
    src_ok = 3'b011;
    k = 0;
    while (cgm_sel != 2'b00 && k < 4) begin
      k++;
      tick();
    end
    chk("fb_lat", k, 3);
    chk("fb_sel", cgm_sel, 0);
    chk("fb_code", err_code, 2'b10);
    chk("fb_err", err_pulse, 1);
    chk("fb_busy", busy, 1);
    wait_busy(nb);
    chk("fb_ncyc", nb, 16);
    chk("fb_cur", cur_src, 0);
    chk("fb_done", done_pulse, 0);

    // no fallback when disabled
    src_ok = 3'b111;
    fallback_en = 1'b0;
    ticks(3);
    do_req(2'b10);
    wait_busy(nb);
    tick();
    src_ok = 3'b011;
    ticks(6);
    chk("nofb_sel", cgm_sel, 2'b10);
    chk("nofb_busy", busy, 0);
    chk("nofb_cur", cur_src, 2);
    chk("nofb_code", err_code, 2'b10);
    src_ok = 3'b111;
    ticks(3);

    // target lost mid-switch at cnt=8
    do_req(2'b01);
    ticks(7);
    src_ok = 3'b101;
    k = 0;
    while (cgm_sel != 2'b00 && k < 5) begin
      k++;
      tick();
    end
    chk("ab_lat", k, 3);
    chk("ab_code", err_code, 2'b11);
    chk("ab_err", err_pulse, 1);
    chk("ab_busy", busy, 1);
    wait_busy(nb);
    chk("ab_ncyc", nb, 16);
    chk("ab_cur", cur_src, 0);
    chk("ab_done", done_pulse, 0);

    // fallback beats a simultaneous request
    src_ok = 3'b111;
    fallback_en = 1'b1;
    ticks(3);
    do_req(2'b10);
    wait_busy(nb);
    chk("sim_pre_cur", cur_src, 2);
    src_ok = 3'b011;
    ticks(2);
    rif.req_valid = 1'b1;
    rif.req_sel = 2'b01;
    chk("sim_rdy", rif.req_ready, 0);
    tick();
    rif.req_valid = 1'b0;
    chk("sim_sel", cgm_sel, 0);
    chk("sim_code", err_code, 2'b10);
    chk("sim_busy", busy, 1);

    // async reset in the middle of the switch
    ticks(3);
    #2;
    rst_clk = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_sel", cgm_sel, 0);
    chk("ar_cur", cur_src, 0);
    chk("ar_code", err_code, 0);
    ticks(2);
    rst_clk = 1'b0;
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
